// File: rtl/fir_sample_loader.sv
// FIR sample loader: clears the sample memory, then moves FIFO
// samples into a circular buffer and hands each one to the MAC.
module fir_sample_loader #(
  parameter  int DATA_W = 16,
  parameter  int TAPS   = 64,
  parameter  int DROP_N = 0,
  localparam int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_out,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mac_start,
  input  logic              mac_done,
  output logic [ADDR_W-1:0] head,
  output logic              primed,
  output logic              busy
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(TAPS);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_POP,
    S_CAPT,
    S_WRITE,
    S_START,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        drop_cnt;
  logic [CNT_W-1:0]  count;
  logic              restart;

  assign restart = rst | clear;
  assign primed  = (count == FULL);

  // State register; a clear or reset overrides every transition.
  always_ff @(posedge clk) begin
    if (restart) state <= S_CLEAR;
    else         state <= state_nx;
  end

  // Next-state logic and Moore-decoded strobes.
  always_comb begin
    state_nx  = state;
    fifo_rd   = 1'b0;
    mac_start = 1'b0;
    mem_cen   = 1'b1;
    mem_wen   = 1'b1;
    busy      = 1'b1;
    unique case (state)
      S_CLEAR: begin
        mem_cen = 1'b0;
        mem_wen = 1'b0;
        if (mem_addr == LAST) state_nx = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) state_nx = S_POP;
      end
      S_POP: begin
        fifo_rd  = 1'b1;
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        if (drop_cnt != 8'd0) state_nx = S_IDLE;
        else                  state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        state_nx = S_START;
      end
      S_START: begin
        mac_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (mac_done) state_nx = S_IDLE;
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  // Datapath: mem_addr doubles as the clear sweep counter and
  // is loaded with the write pointer just before each write.
  always_ff @(posedge clk) begin
    if (restart) begin
      mem_addr <= '0;
      mem_d    <= '0;
      wr_ptr   <= '0;
      head     <= LAST;
      drop_cnt <= 8'(DROP_N);
      count    <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (mem_addr != LAST) mem_addr <= mem_addr + 1'b1;
        end
        S_CAPT: begin
          if (drop_cnt != 8'd0) begin
            drop_cnt <= drop_cnt - 1'b1;
          end else begin
            mem_addr <= wr_ptr;
            mem_d    <= fifo_out;
          end
        end
        S_WRITE: begin
          head   <= wr_ptr;
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          if (count != FULL) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
